// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, grant ids and the
// captured request record.
package rv32i_mem_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  typedef enum logic {
    GrantInst = 1'b0,
    GrantData = 1'b1
  } grant_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wr;
  } req_t;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Single-port memory bus with a one-cycle stb pulse and a one-cycle ack.
interface rv32i_mem_arbiter_if;

  logic        stb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wr_mask;
  logic        wr_en;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output stb, addr, wdata, wr_mask, wr_en,
    input  ack, rdata
  );

  modport slave (
    input  stb, addr, wdata, wr_mask, wr_en,
    output ack, rdata
  );

endinterface

// File: rtl/rv32i_mem_arbiter_req_latch.sv
// One requester's capture register and pending flag; a new pulse is only taken
// while nothing is pending.
module rv32i_mem_arbiter_req_latch
  import rv32i_mem_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stb,
  input  logic i_discard,
  input  logic i_clear,
  input  req_t i_req,
  output req_t o_req,
  output logic o_pending
);

  req_t r_req;
  logic r_pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req     <= '0;
      r_pending <= 1'b0;
    end else if (r_pending) begin
      if (i_clear) begin
        r_pending <= 1'b0;
      end
    end else if (i_stb && !i_discard) begin
      r_req     <= i_req;
      r_pending <= 1'b1;
    end
  end

  assign o_req     = r_req;
  assign o_pending = r_pending;

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the data stage,
// one transaction at a time, with a timeout against a silent memory.
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_stb_inst,
  input  logic [31:0]                i_addr_inst,
  input  logic                       i_flush_inst,
  output logic                       o_ack_inst,
  output logic [31:0]                o_inst,
  input  logic                       i_stb_data,
  input  logic [31:0]                i_addr_data,
  input  logic [31:0]                i_wdata_data,
  input  logic [3:0]                 i_wr_mask_data,
  input  logic                       i_wr_data,
  output logic                       o_ack_data,
  output logic [31:0]                o_rdata_data,
  output logic                       o_err,
  output logic                       o_busy,
  rv32i_mem_arbiter_if.master        mem
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  state_e            r_state, w_state_d;
  grant_e            r_grant, w_grant_d;
  grant_e            r_last_grant, w_last_grant_d;
  logic [TimerW-1:0] r_timer, w_timer_d;
  logic              r_drop, w_drop_d;
  logic              r_stb_mem, w_stb_mem_d;
  logic [31:0]       r_addr_mem, w_addr_mem_d;
  logic [31:0]       r_wdata_mem, w_wdata_mem_d;
  logic [3:0]        r_mask_mem, w_mask_mem_d;
  logic              r_wr_en_mem, w_wr_en_mem_d;
  logic              r_ack_inst, w_ack_inst_d;
  logic              r_ack_data, w_ack_data_d;
  logic              r_err, w_err_d;
  logic [31:0]       r_inst, w_inst_d;
  logic [31:0]       r_rdata, w_rdata_d;
  logic              r_busy;

  req_t w_inst_in, w_data_in, w_inst_req, w_data_req, w_sel;
  logic w_pend_inst, w_pend_data, w_req_inst, w_pick_data;
  logic w_done_inst, w_done_data, w_clear_inst, w_inflight_inst, w_timeout, w_drop;

  assign w_inst_in = '{addr: i_addr_inst, wdata: 32'h0, mask: 4'h0, wr: 1'b0};
  assign w_data_in = '{addr: i_addr_data, wdata: i_wdata_data, mask: i_wr_mask_data,
                       wr: i_wr_data};

  assign w_inflight_inst = (r_state == StBusy) && (r_grant == GrantInst);
  // A flush only clears the pending fetch while it has not been granted yet.
  assign w_clear_inst = w_done_inst || (i_flush_inst && !w_inflight_inst);

  rv32i_mem_arbiter_req_latch u_inst_latch (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_stb     (i_stb_inst),
    .i_discard (i_flush_inst),
    .i_clear   (w_clear_inst),
    .i_req     (w_inst_in),
    .o_req     (w_inst_req),
    .o_pending (w_pend_inst)
  );

  rv32i_mem_arbiter_req_latch u_data_latch (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_stb     (i_stb_data),
    .i_discard (1'b0),
    .i_clear   (w_done_data),
    .i_req     (w_data_in),
    .o_req     (w_data_req),
    .o_pending (w_pend_data)
  );

  assign w_req_inst  = w_pend_inst && !i_flush_inst;
  assign w_pick_data = w_pend_data && (!w_req_inst || (r_last_grant == GrantInst));
  assign w_sel       = w_pick_data ? w_data_req : w_inst_req;
  assign w_timeout   = (r_timer == TimerLast);
  assign w_drop      = r_drop || i_flush_inst;

  always_comb begin
    w_state_d      = r_state;
    w_grant_d      = r_grant;
    w_last_grant_d = r_last_grant;
    w_timer_d      = r_timer;
    w_drop_d       = r_drop;
    w_stb_mem_d    = 1'b0;
    w_addr_mem_d   = r_addr_mem;
    w_wdata_mem_d  = r_wdata_mem;
    w_mask_mem_d   = r_mask_mem;
    w_wr_en_mem_d  = r_wr_en_mem;
    w_ack_inst_d   = 1'b0;
    w_ack_data_d   = 1'b0;
    w_err_d        = 1'b0;
    w_inst_d       = r_inst;
    w_rdata_d      = r_rdata;
    w_done_inst    = 1'b0;
    w_done_data    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req_inst || w_pend_data) begin
          w_grant_d      = w_pick_data ? GrantData : GrantInst;
          w_last_grant_d = w_grant_d;
          w_state_d      = StBusy;
          w_timer_d      = '0;
          w_drop_d       = 1'b0;
          w_stb_mem_d    = 1'b1;
          w_addr_mem_d   = w_sel.addr;
          w_wdata_mem_d  = w_sel.wdata;
          w_mask_mem_d   = w_sel.mask;
          w_wr_en_mem_d  = w_sel.wr;
        end
      end
      StBusy: begin
        if (mem.ack || w_timeout) begin
          w_state_d     = StIdle;
          w_mask_mem_d  = 4'h0;
          w_wr_en_mem_d = 1'b0;
          if (r_grant == GrantInst) begin
            w_done_inst = 1'b1;
            if (!w_drop) begin
              w_ack_inst_d = 1'b1;
              w_err_d      = !mem.ack;
              w_inst_d     = mem.ack ? mem.rdata : 32'h0;
            end
          end else begin
            w_done_data  = 1'b1;
            w_ack_data_d = 1'b1;
            w_err_d      = !mem.ack;
            w_rdata_d    = mem.ack ? mem.rdata : 32'h0;
          end
        end else begin
          w_timer_d = r_timer + TimerW'(1);
          if (i_flush_inst && (r_grant == GrantInst)) begin
            w_drop_d = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_grant      <= GrantInst;
      r_last_grant <= GrantInst;
      r_timer      <= '0;
      r_drop       <= 1'b0;
      r_stb_mem    <= 1'b0;
      r_addr_mem   <= 32'h0;
      r_wdata_mem  <= 32'h0;
      r_mask_mem   <= 4'h0;
      r_wr_en_mem  <= 1'b0;
      r_ack_inst   <= 1'b0;
      r_ack_data   <= 1'b0;
      r_err        <= 1'b0;
      r_inst       <= 32'h0;
      r_rdata      <= 32'h0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_grant      <= w_grant_d;
      r_last_grant <= w_last_grant_d;
      r_timer      <= w_timer_d;
      r_drop       <= w_drop_d;
      r_stb_mem    <= w_stb_mem_d;
      r_addr_mem   <= w_addr_mem_d;
      r_wdata_mem  <= w_wdata_mem_d;
      r_mask_mem   <= w_mask_mem_d;
      r_wr_en_mem  <= w_wr_en_mem_d;
      r_ack_inst   <= w_ack_inst_d;
      r_ack_data   <= w_ack_data_d;
      r_err        <= w_err_d;
      r_inst       <= w_inst_d;
      r_rdata      <= w_rdata_d;
      r_busy       <= (r_state != StIdle) || w_pend_inst || w_pend_data;
    end
  end

  assign o_ack_inst   = r_ack_inst;
  assign o_inst       = r_inst;
  assign o_ack_data   = r_ack_data;
  assign o_rdata_data = r_rdata;
  assign o_err        = r_err;
  assign o_busy       = r_busy;
  assign mem.stb      = r_stb_mem;
  assign mem.addr     = r_addr_mem;
  assign mem.wdata    = r_wdata_mem;
  assign mem.wr_mask  = r_mask_mem;
  assign mem.wr_en    = r_wr_en_mem;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: each task drives one scenario and
// checks hand-computed cycle-by-cycle expectations.
`timescale 1ns/1ps
module tb_rv32i_mem_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stb_inst;
  logic [31:0] i_addr_inst;
  logic        i_flush_inst;
  logic        o_ack_inst;
  logic [31:0] o_inst;
  logic        i_stb_data;
  logic [31:0] i_addr_data;
  logic [31:0] i_wdata_data;
  logic [3:0]  i_wr_mask_data;
  logic        i_wr_data;
  logic        o_ack_data;
  logic [31:0] o_rdata_data;
  logic        o_err;
  logic        o_busy;

  int n_pass;
  int n_total;

  rv32i_mem_arbiter_if mem_bus ();

  rv32i_mem_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_stb_inst     (i_stb_inst),
    .i_addr_inst    (i_addr_inst),
    .i_flush_inst   (i_flush_inst),
    .o_ack_inst     (o_ack_inst),
    .o_inst         (o_inst),
    .i_stb_data     (i_stb_data),
    .i_addr_data    (i_addr_data),
    .i_wdata_data   (i_wdata_data),
    .i_wr_mask_data (i_wr_mask_data),
    .i_wr_data      (i_wr_data),
    .o_ack_data     (o_ack_data),
    .o_rdata_data   (o_rdata_data),
    .o_err          (o_err),
    .o_busy         (o_busy),
    .mem            (mem_bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance n clock edges; land 1ns after the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) $display("FAIL %s: got %h want %h", name, got, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick(2);
    n_total++;
    if ({o_ack_inst, o_ack_data, o_err, o_busy, mem_bus.stb, mem_bus.wr_en, mem_bus.wr_mask}
        !== 10'b0)
      $display("FAIL reset_ctrl: got %b want 0", {o_ack_inst, o_ack_data, o_err, o_busy,
               mem_bus.stb, mem_bus.wr_en, mem_bus.wr_mask});
    else n_pass++;
    n_total++;
    if ({o_inst, o_rdata_data, mem_bus.addr, mem_bus.wdata} !== 128'b0)
      $display("FAIL reset_data: got %h want 0", {o_inst, o_rdata_data, mem_bus.addr,
               mem_bus.wdata});
    else n_pass++;
    i_rst_n = 1'b1;
    tick(2);
    n_total++;
    if (o_busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", o_busy);
    else n_pass++;
  endtask

  task automatic test_fetch();
    i_stb_inst = 1'b1; i_addr_inst = 32'h100;
    tick(1);
    i_stb_inst = 1'b0; i_addr_inst = 32'h0;
    n_total++;
    if (mem_bus.stb !== 1'b0) $display("FAIL fetch_stb_early: got %b want 0", mem_bus.stb);
    else n_pass++;
    tick(1);
    n_total++;
    if (mem_bus.stb !== 1'b1) $display("FAIL fetch_stb: got %b want 1", mem_bus.stb);
    else n_pass++;
    n_total++;
    if (mem_bus.addr !== 32'h100) $display("FAIL fetch_addr: got %h want 100", mem_bus.addr);
    else n_pass++;
    n_total++;
    if (mem_bus.wr_en !== 1'b0) $display("FAIL fetch_wr_en: got %b want 0", mem_bus.wr_en);
    else n_pass++;
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h0000_0013;
    tick(1);
    mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
    n_total++;
    if ({o_ack_inst, o_ack_data, o_err, mem_bus.stb} !== 4'b1000)
      $display("FAIL fetch_ack: got %b want 1000", {o_ack_inst, o_ack_data, o_err, mem_bus.stb});
    else n_pass++;
    n_total++;
    if (o_inst !== 32'h13) $display("FAIL fetch_inst: got %h want 00000013", o_inst);
    else n_pass++;
    tick(1);
    n_total++;
    if (o_ack_inst !== 1'b0) $display("FAIL fetch_ack_pulse: got %b want 0", o_ack_inst);
    else n_pass++;
  endtask

  task automatic test_tie();
    i_stb_inst = 1'b1; i_addr_inst = 32'h104;
    i_stb_data = 1'b1; i_addr_data = 32'h3000; i_wr_data = 1'b0;
    tick(1);
    i_stb_inst = 1'b0; i_stb_data = 1'b0;
    tick(1);
    n_total++;
    if ({mem_bus.stb, mem_bus.addr} !== {1'b1, 32'h3000})
      $display("FAIL tie_first: got %b/%h want 1/00003000", mem_bus.stb, mem_bus.addr);
    else n_pass++;
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'hDEAD_BEEF;
    tick(1);
    mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
    n_total++;
    if ({o_ack_data, o_ack_inst, mem_bus.stb} !== 3'b100)
      $display("FAIL tie_data_ack: got %b want 100", {o_ack_data, o_ack_inst, mem_bus.stb});
    else n_pass++;
    n_total++;
    if (o_rdata_data !== 32'hDEAD_BEEF)
      $display("FAIL tie_rdata: got %h want deadbeef", o_rdata_data);
    else n_pass++;
    tick(1);
    n_total++;
    if ({mem_bus.stb, mem_bus.addr} !== {1'b1, 32'h104})
      $display("FAIL tie_second: got %b/%h want 1/00000104", mem_bus.stb, mem_bus.addr);
    else n_pass++;
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h55;
    tick(1);
    mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
    n_total++;
    if ({o_ack_inst, o_ack_data, o_inst} !== {2'b10, 32'h55})
      $display("FAIL tie_inst_ack: got %b%b/%h want 10/00000055", o_ack_inst, o_ack_data, o_inst);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_store();
    i_stb_data = 1'b1; i_addr_data = 32'h2002; i_wdata_data = 32'h00AB_0000;
    i_wr_mask_data = 4'b0100; i_wr_data = 1'b1;
    tick(1);
    i_stb_data = 1'b0; i_wdata_data = 32'h0; i_wr_mask_data = 4'h0; i_wr_data = 1'b0;
    tick(1);
    n_total++;
    if ({mem_bus.stb, mem_bus.wr_en, mem_bus.wr_mask} !== 6'b11_0100)
      $display("FAIL store_ctrl: got %b want 110100", {mem_bus.stb, mem_bus.wr_en,
               mem_bus.wr_mask});
    else n_pass++;
    n_total++;
    if ({mem_bus.addr, mem_bus.wdata} !== {32'h2002, 32'h00AB_0000})
      $display("FAIL store_addr_wdata: got %h/%h want 00002002/00ab0000", mem_bus.addr,
               mem_bus.wdata);
    else n_pass++;
    tick(1);
    n_total++;
    if ({mem_bus.stb, mem_bus.wr_en, mem_bus.wr_mask, o_busy} !== 7'b01_0100_1)
      $display("FAIL store_hold: got %b want 0101001", {mem_bus.stb, mem_bus.wr_en,
               mem_bus.wr_mask, o_busy});
    else n_pass++;
    mem_bus.ack = 1'b1;
    tick(1);
    mem_bus.ack = 1'b0;
    n_total++;
    if ({o_ack_data, o_err, mem_bus.wr_en, mem_bus.wr_mask} !== 7'b10_0_0000)
      $display("FAIL store_done: got %b want 1000000", {o_ack_data, o_err, mem_bus.wr_en,
               mem_bus.wr_mask});
    else n_pass++;
    tick(1);
  endtask

  task automatic test_timeout();
    i_stb_data = 1'b1; i_addr_data = 32'h4000; i_wr_data = 1'b0;
    tick(1);
    i_stb_data = 1'b0;
    mem_bus.rdata = 32'hFFFF_FFFF;
    tick(1);
    n_total++;
    if (mem_bus.stb !== 1'b1) $display("FAIL timeout_stb: got %b want 1", mem_bus.stb);
    else n_pass++;
    tick(7);
    n_total++;
    if ({o_ack_data, o_err} !== 2'b00)
      $display("FAIL timeout_early: got %b want 00", {o_ack_data, o_err});
    else n_pass++;
    tick(1);
    n_total++;
    if ({o_ack_data, o_err, o_rdata_data} !== {2'b11, 32'h0})
      $display("FAIL timeout_abort: got %b%b/%h want 11/00000000", o_ack_data, o_err,
               o_rdata_data);
    else n_pass++;
    mem_bus.rdata = 32'h0;
    tick(1);
    n_total++;
    if ({o_ack_data, o_err, o_busy} !== 3'b000)
      $display("FAIL timeout_idle: got %b want 000", {o_ack_data, o_err, o_busy});
    else n_pass++;
  endtask

  task automatic test_flush();
    // Flush together with the strobe: the fetch never reaches memory.
    i_stb_inst = 1'b1; i_flush_inst = 1'b1; i_addr_inst = 32'h300;
    tick(1);
    i_stb_inst = 1'b0; i_flush_inst = 1'b0;
    tick(2);
    n_total++;
    if ({mem_bus.stb, o_busy} !== 2'b00)
      $display("FAIL flush_same_cycle: got %b want 00", {mem_bus.stb, o_busy});
    else n_pass++;
    // In-flight fetch flushed, data load queued behind it.
    i_stb_inst = 1'b1; i_addr_inst = 32'h200;
    tick(1);
    i_stb_inst = 1'b0;
    i_stb_data = 1'b1; i_addr_data = 32'h5000; i_wr_data = 1'b0;
    tick(1);
    i_stb_data = 1'b0;
    n_total++;
    if ({mem_bus.stb, mem_bus.addr} !== {1'b1, 32'h200})
      $display("FAIL flush_fetch_stb: got %b/%h want 1/00000200", mem_bus.stb, mem_bus.addr);
    else n_pass++;
    i_flush_inst = 1'b1;
    tick(1);
    i_flush_inst = 1'b0;
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h77;
    tick(1);
    mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
    n_total++;
    if ({o_ack_inst, o_err, o_ack_data} !== 3'b000)
      $display("FAIL flush_suppress: got %b want 000", {o_ack_inst, o_err, o_ack_data});
    else n_pass++;
    tick(1);
    n_total++;
    if ({mem_bus.stb, mem_bus.addr, o_ack_inst} !== {1'b1, 32'h5000, 1'b0})
      $display("FAIL flush_data_grant: got %b/%h/%b want 1/00005000/0", mem_bus.stb,
               mem_bus.addr, o_ack_inst);
    else n_pass++;
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'h1234_5678;
    tick(1);
    mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
    n_total++;
    if ({o_ack_data, o_err, o_ack_inst, o_rdata_data} !== {3'b100, 32'h1234_5678})
      $display("FAIL flush_data_ack: got %b%b%b/%h want 100/12345678", o_ack_data, o_err,
               o_ack_inst, o_rdata_data);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_reset_mid_busy();
    i_stb_inst = 1'b1; i_addr_inst = 32'h400;
    tick(1);
    i_stb_inst = 1'b0;
    tick(2);
    n_total++;
    if ({o_busy, mem_bus.addr} !== {1'b1, 32'h400})
      $display("FAIL rst_busy_pre: got %b/%h want 1/00000400", o_busy, mem_bus.addr);
    else n_pass++;
    i_rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_ack_inst, o_ack_data, o_err, o_busy, mem_bus.stb, mem_bus.addr, o_inst}
        !== 69'b0)
      $display("FAIL rst_async: got %h want 0", {o_ack_inst, o_ack_data, o_err, o_busy,
               mem_bus.stb, mem_bus.addr, o_inst});
    else n_pass++;
    tick(1);
    i_rst_n = 1'b1;
    mem_bus.ack = 1'b1; mem_bus.rdata = 32'hCAFE_F00D;
    tick(1);
    mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
    n_total++;
    if ({o_ack_inst, o_ack_data, o_err, o_busy, mem_bus.stb} !== 5'b0)
      $display("FAIL rst_stale_ack: got %b want 00000", {o_ack_inst, o_ack_data, o_err,
               o_busy, mem_bus.stb});
    else n_pass++;
    tick(1);
    n_total++;
    if ({o_ack_inst, o_inst, o_busy} !== 34'b0)
      $display("FAIL rst_after: got %b/%h/%b want 0/00000000/0", o_ack_inst, o_inst, o_busy);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    i_rst_n = 1'b0;
    i_stb_inst = 1'b0; i_addr_inst = 32'h0; i_flush_inst = 1'b0;
    i_stb_data = 1'b0; i_addr_data = 32'h0; i_wdata_data = 32'h0;
    i_wr_mask_data = 4'h0; i_wr_data = 1'b0;
    mem_bus.ack = 1'b0; mem_bus.rdata = 32'h0;
    test_reset();
    test_fetch();
    test_tie();
    test_store();
    test_timeout();
    test_flush();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
